// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and widths for the sequential multiplier
package mul_pkg;

    localparam int MUL_W     = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        PREPARE   = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

endpackage

// File: rtl/LZC_32bit.sv
// rtl/LZC_32bit.sv - leading-zero count of a 32-bit word (32 when all zero)
module LZC_32bit (
    input  logic [31:0] i_data,
    output logic [5:0]  o_count,
    output logic        o_all_zero
);

    // Scanning upward lets the highest set bit write last and win.
    always_comb begin
        o_count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_data[i]) begin
                o_count = 6'(31 - i);
            end
        end
    end

    assign o_all_zero = ~|i_data;

endmodule

// File: rtl/full_adder_32bit.sv
// rtl/full_adder_32bit.sv - 32-bit adder with carry in and carry out
module full_adder_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'b0, i_cin};

endmodule

// File: rtl/register_32bit.sv
// rtl/register_32bit.sv - 32-bit load-enable register with async clear
module register_32bit (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/multiplier_32x32.sv
// rtl/multiplier_32x32.sv - sequential unsigned 32x32->64 shift-and-add multiplier
module multiplier_32x32
    import mul_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MUL_W-1:0]     A,
    input  logic [MUL_W-1:0]     B,
    output logic [2*MUL_W-1:0]   product,
    output logic                 overflow,
    output logic                 ready,
    output logic                 valid
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [MUL_W-1:0]       r_a_f;
    logic [MUL_W-1:0]       r_b_f;
    logic [2*MUL_W-1:0]     r_mcand;
    logic [2*MUL_W-1:0]     r_acc;
    logic [MUL_W-1:0]       r_mplr;
    logic [MUL_CNT_W-1:0]   r_cnt;
    logic                   r_overflow;
    logic                   r_valid;

    logic                   w_is_fetch;
    logic                   w_is_prep;
    logic                   w_is_exec;
    logic                   w_is_wb;
    logic [MUL_CNT_W-1:0]   w_nlz;
    logic                   w_b_zero;
    logic [MUL_CNT_W-1:0]   w_n;
    logic [2*MUL_W-1:0]     w_addend;
    logic [2*MUL_W-1:0]     w_sum;
    logic [2*MUL_W-1:0]     w_mcand_d;
    logic [2*MUL_W-1:0]     w_acc_d;
    logic                   w_carry_lo;
    logic                   w_unused_carry_hi;

    assign w_is_fetch = (r_state == FETCH);
    assign w_is_prep  = (r_state == PREPARE);
    assign w_is_exec  = (r_state == EXECUTE);
    assign w_is_wb    = (r_state == WRITEBACK);

    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:      w_state_next = start ? FETCH : IDLE;
            FETCH:     w_state_next = PREPARE;
            PREPARE:   w_state_next = w_b_zero ? WRITEBACK : EXECUTE;
            EXECUTE:   w_state_next = (r_cnt == MUL_CNT_W'(1)) ? WRITEBACK : EXECUTE;
            WRITEBACK: w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    register_32bit u_a_f (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_fetch), .i_d(A), .o_q(r_a_f));
    register_32bit u_b_f (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_fetch), .i_d(B), .o_q(r_b_f));

    LZC_32bit u_lzc (
        .i_data     (r_b_f),
        .o_count    (w_nlz),
        .o_all_zero (w_b_zero)
    );

    // Iterations only cover the significant bits of the multiplier.
    assign w_n = w_b_zero ? '0 : (MUL_CNT_W'(MUL_W) - w_nlz);

    assign w_addend = r_mplr[0] ? r_mcand : '0;

    full_adder_32bit u_add_lo (
        .i_a    (r_acc[MUL_W-1:0]),
        .i_b    (w_addend[MUL_W-1:0]),
        .i_cin  (1'b0),
        .o_sum  (w_sum[MUL_W-1:0]),
        .o_cout (w_carry_lo)
    );

    full_adder_32bit u_add_hi (
        .i_a    (r_acc[2*MUL_W-1:MUL_W]),
        .i_b    (w_addend[2*MUL_W-1:MUL_W]),
        .i_cin  (w_carry_lo),
        .o_sum  (w_sum[2*MUL_W-1:MUL_W]),
        .o_cout (w_unused_carry_hi)
    );

    assign w_mcand_d = w_is_prep ? {{MUL_W{1'b0}}, r_a_f} : {r_mcand[2*MUL_W-2:0], 1'b0};
    assign w_acc_d   = w_is_prep ? '0 : w_sum;

    register_32bit u_mcand_lo (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_prep | w_is_exec),
                               .i_d(w_mcand_d[MUL_W-1:0]), .o_q(r_mcand[MUL_W-1:0]));
    register_32bit u_mcand_hi (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_prep | w_is_exec),
                               .i_d(w_mcand_d[2*MUL_W-1:MUL_W]), .o_q(r_mcand[2*MUL_W-1:MUL_W]));
    register_32bit u_acc_lo   (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_prep | w_is_exec),
                               .i_d(w_acc_d[MUL_W-1:0]), .o_q(r_acc[MUL_W-1:0]));
    register_32bit u_acc_hi   (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_prep | w_is_exec),
                               .i_d(w_acc_d[2*MUL_W-1:MUL_W]), .o_q(r_acc[2*MUL_W-1:MUL_W]));

    // product only loads in WRITEBACK, so an aborted run never reaches it.
    register_32bit u_prod_lo  (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_wb),
                               .i_d(r_acc[MUL_W-1:0]), .o_q(product[MUL_W-1:0]));
    register_32bit u_prod_hi  (.clk_i(clk_i), .rst_n(rst_n), .i_en(w_is_wb),
                               .i_d(r_acc[2*MUL_W-1:MUL_W]), .o_q(product[2*MUL_W-1:MUL_W]));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mplr     <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_is_wb;
            if (w_is_prep) begin
                r_cnt  <= w_n;
                r_mplr <= r_b_f;
            end else if (w_is_exec) begin
                r_cnt  <= r_cnt - MUL_CNT_W'(1);
                r_mplr <= {1'b0, r_mplr[MUL_W-1:1]};
            end
            if (w_is_wb) begin
                r_overflow <= |r_acc[2*MUL_W-1:MUL_W];
            end
        end
    end

    assign ready    = (r_state == IDLE);
    assign valid    = r_valid;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_multiplier_32x32.sv
// tb/tb_multiplier_32x32.sv - scoreboard bench for multiplier_32x32
module tb_multiplier_32x32;

    logic        clk_i;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] product;
    logic        overflow;
    logic        ready;
    logic        valid;

    typedef struct {
        logic [63:0] p;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    multiplier_32x32 dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .product  (product),
        .overflow (overflow),
        .ready    (ready),
        .valid    (valid)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk_i) begin
        exp_t e;
        if (valid === 1'b1) begin
            check("valid_one_cycle", 64'(prev_valid), 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%h required=none", product);
            end else begin
                e = sb.pop_front();
                check("product", product, e.p);
                check("overflow", 64'(overflow), 64'(e.ovf));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
                check("ready_with_valid", 64'(ready), 64'd1);
            end
        end
        prev_valid = valid;
    end

    task automatic wait_idle();
        int k = 0;
        while (ready !== 1'b1 && k < 60) begin
            @(negedge clk_i);
            k++;
        end
        check("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input logic ovf, input int n);
        exp_t e;
        @(negedge clk_i);
        A = a;
        B = b;
        start = 1'b1;
        e.p = p;
        e.ovf = ovf;
        e.cyc = cyc + 1 + n + 3;
        sb.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
        check("ready_busy", 64'(ready), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        A = 32'hA5A5_5A5A;
        B = 32'h5A5A_A5A5;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_product", product, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        rst_n = 1'b1;

        do_op(32'd7, 32'd6, 64'd42, 1'b0, 3);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 32);
        do_op(32'h1234_5678, 32'd0, 64'd0, 1'b0, 0);
        do_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1, 2);
        do_op(32'd0, 32'd1, 64'd0, 1'b0, 1);
        do_op(32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1);
        do_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1, 17);
        do_op(32'hDEAD_BEEF, 32'h0000_0010, 64'h0000_000D_EADB_EEF0, 1'b1, 5);

        // start and operands wiggle while the 3*5 run is in EXECUTE.
        @(negedge clk_i);
        A = 32'd3;
        B = 32'd5;
        start = 1'b1;
        e.p = 64'd15;
        e.ovf = 1'b0;
        e.cyc = cyc + 1 + 3 + 3;
        sb.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b1;
        A = 32'd7;
        B = 32'd7;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
        A = 32'd1;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b1;
        B = 32'd9;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
        wait_idle();
        repeat (6) @(negedge clk_i);

        // Reset lands mid-EXECUTE of 9*9; nothing may reach product.
        A = 32'd9;
        B = 32'd9;
        start = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_product", product, 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        check("postrst_ready", 64'(ready), 64'd1);
        repeat (8) @(negedge clk_i);
        check("postrst_product", product, 64'd0);

        do_op(32'd9, 32'd9, 64'd81, 1'b0, 4);

        repeat (4) @(negedge clk_i);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_32x32.md
# multiplier_32x32

Sequential unsigned 32×32→64 shift-and-add multiplier. It is the companion of the team's sequential divider, and the datapath's multi-cycle arithmetic unit uses it for MUL/MULHU. It uses the same start/ready handshake and five-state control flow: IDLE, FETCH, PREPARE, EXECUTE, WRITEBACK. The iteration count is trimmed by the leading-zero count of B, so small multipliers finish early.

## Interface
Parameters: none. Width fixed at 32.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while in IDLE
- A  in  32  multiplicand, unsigned
- B  in  32  multiplier, unsigned
- product  out  64  A×B; holds the last result until the next WRITEBACK
- overflow  out  1  registered; equals product[63:32] != 0; updated with product
- ready  out  1  combinational; high iff state == IDLE
- valid  out  1  registered one-cycle pulse; high in the cycle after WRITEBACK

## Operation
- State transitions:
  - IDLE → FETCH if start, else stay in IDLE.
  - FETCH → PREPARE, unconditionally.
  - PREPARE → WRITEBACK if N == 0, else → EXECUTE.
  - EXECUTE → WRITEBACK when cnt == 1, else stay in EXECUTE.
  - WRITEBACK → IDLE.
  - Any illegal encoding → IDLE.
- FETCH: latch A into a_f and B into b_f. A and B are don't-care in every other state.
- PREPARE:
  - N = 32 − NLZ(b_f), 6-bit. N = 0 when b_f == 0; N = 32 when b_f[31] == 1.
  - Load cnt ← N.
  - Load mcand (64 bit) ← {32'b0, a_f}.
  - Load mplr ← b_f.
  - Clear acc (64 bit).
- EXECUTE, once per cycle:
  - acc ← acc + (mplr[0] ? mcand : 0), as a 64-bit modulo add. The true sum never exceeds 2^64 − 1.
  - mcand ← mcand << 1.
  - mplr ← mplr >> 1.
  - cnt ← cnt − 1.
  - EXECUTE lasts exactly N cycles.
- WRITEBACK:
  - product ← acc.
  - overflow ← |acc[63:32].
  - valid ← 1 on the next edge. valid is 0 in all other cycles.
- start while not in IDLE: ignored. It is not queued.
- start held high continuously: a new operation begins each time the FSM returns to IDLE. IDLE lasts one cycle between operations.
- Reset, at any time including mid-EXECUTE:
  - State returns to IDLE.
  - product = 0, overflow = 0, valid = 0.
  - All internal registers (a_f, b_f, mcand, mplr, acc, cnt) = 0.
  - ready = 1 while in reset and immediately after.
  - A partial result is never written to product.

## Timing
- Edge e0 samples start = 1 in IDLE.
- Results appear on product and overflow after edge e(N+3), together with valid = 1 and ready = 1.
- Latency from the start-sampling edge is N+3 cycles:
  - minimum 3 (B = 0)
  - maximum 35 (B[31] = 1)
- ready is low from e0 until edge e(N+3).
- No combinational path from the inputs (A, B, start) to product, overflow or valid.

## Structure
- Package mul_pkg holds:
  - the state typedef: 3-bit enum with IDLE = 0, FETCH = 1, PREPARE = 2, EXECUTE = 3, WRITEBACK = 4
  - the constant MUL_W = 32
  - the constant MUL_CNT_W = 6
- Sub-module: the existing LZC_32bit computes NLZ(b_f). Its all_zero output selects the N = 0 path.
- Datapath registers use the existing register_32bit, in pairs for the 64-bit registers. Adds use full_adder_32bit ×2, chained through carry.
- The FSM, counter and shift registers live in this module. The target is about 200 lines.

## Test plan
- A = 7, B = 6 (N = 3) → product = 42 and overflow = 0 after 6 cycles; valid pulses for exactly 1 cycle.
- A = 0xFFFFFFFF, B = 0xFFFFFFFF (N = 32) → product = 0xFFFFFFFE00000001 and overflow = 1 after 35 cycles.
- A = 0x12345678, B = 0 → product = 0 and overflow = 0 after 3 cycles; EXECUTE is never entered.
- A = 0x80000000, B = 2 (N = 2) → product = 0x0000000100000000, overflow = 1; then A = 0, B = 1 → product = 0, overflow = 0.
- Toggle start and change A/B during EXECUTE of A = 3, B = 5 → product = 15; no extra operation starts.
- Assert rst_n low mid-EXECUTE of A = 9, B = 9 → state IDLE, product = 0, valid = 0, ready = 1. Then A = 9, B = 9 → product = 81.
